// File: rtl/lc3b_fetch_ctrl_if.sv
// Fetch-side bus bundle: instruction-memory handshake, decode stall/redirect inputs,
// and the IR load outputs.
interface lc3b_fetch_ctrl_if;
    logic        imem_read;
    logic [15:0] imem_address;
    logic [15:0] imem_rdata;
    logic        imem_resp;
    logic        id_stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        ir_load;
    logic [15:0] ir_word;
    logic [15:0] ir_pc;
    logic [15:0] fetch_count;

    modport master (
        output imem_read, imem_address, ir_load, ir_word, ir_pc, fetch_count,
        input  imem_rdata, imem_resp, id_stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_read, imem_address, ir_load, ir_word, ir_pc, fetch_count,
        output imem_rdata, imem_resp, id_stall, redirect, redirect_pc
    );
endinterface

// File: rtl/lc3b_fetch_ctrl.sv
// LC-3b instruction-fetch sequencer: owns the fetch PC, runs the imem handshake,
// buffers one word across decode stalls and handles redirects in flight.
module lc3b_fetch_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_INC   = 16'd2
) (
    input  logic               clk,
    input  logic               rst_n,
    lc3b_fetch_ctrl_if.master  bus
);
    typedef enum logic {S_REQ, S_HOLD} state_t;

    state_t      state_reg, state_next;
    logic [15:0] pc_reg, pc_next;
    logic [15:0] hold_reg, hold_next;
    logic        redir_pend_reg, redir_pend_next;
    logic [15:0] redir_tgt_reg, redir_tgt_next;
    logic [15:0] count_reg, count_next;
    logic [15:0] pc_inc;

    assign pc_inc = pc_reg + PC_INC;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= S_REQ;
            pc_reg         <= RESET_PC;
            hold_reg       <= 16'h0000;
            redir_pend_reg <= 1'b0;
            redir_tgt_reg  <= 16'h0000;
            count_reg      <= 16'h0000;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            hold_reg       <= hold_next;
            redir_pend_reg <= redir_pend_next;
            redir_tgt_reg  <= redir_tgt_next;
            count_reg      <= count_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        hold_next        = hold_reg;
        redir_pend_next  = redir_pend_reg;
        redir_tgt_next   = redir_tgt_reg;
        count_next       = count_reg;
        bus.imem_read    = 1'b0;
        bus.imem_address = 16'h0000;
        bus.ir_load      = 1'b0;
        bus.ir_word      = 16'h0000;
        bus.ir_pc        = 16'h0000;
        bus.fetch_count  = 16'h0000;

        // Everything is forced quiet while reset is asserted, including any response.
        if (rst_n) begin
            bus.fetch_count = count_reg;
            case (state_reg)
                S_REQ: begin
                    bus.imem_read    = 1'b1;
                    bus.imem_address = pc_reg;
                    if (bus.imem_resp) begin
                        if (bus.redirect) begin
                            pc_next         = bus.redirect_pc;
                            redir_pend_next = 1'b0;
                        end else if (redir_pend_reg) begin
                            pc_next         = redir_tgt_reg;
                            redir_pend_next = 1'b0;
                        end else if (bus.id_stall) begin
                            hold_next  = bus.imem_rdata;
                            state_next = S_HOLD;
                        end else begin
                            bus.ir_load = 1'b1;
                            bus.ir_word = bus.imem_rdata;
                            bus.ir_pc   = pc_inc;
                            pc_next     = pc_inc;
                            count_next  = count_reg + 16'd1;
                        end
                    end else if (bus.redirect) begin
                        // Address must stay stable until the response, so defer the target.
                        redir_pend_next = 1'b1;
                        redir_tgt_next  = bus.redirect_pc;
                    end
                end
                S_HOLD: begin
                    if (bus.redirect) begin
                        hold_next  = 16'h0000;
                        pc_next    = bus.redirect_pc;
                        state_next = S_REQ;
                    end else if (!bus.id_stall) begin
                        bus.ir_load = 1'b1;
                        bus.ir_word = hold_reg;
                        bus.ir_pc   = pc_inc;
                        pc_next     = pc_inc;
                        count_next  = count_reg + 16'd1;
                        state_next  = S_REQ;
                    end
                end
                default: state_next = S_REQ;
            endcase
        end
    end
endmodule

// File: tb/tb_lc3b_fetch_ctrl.sv
// Randomized bench for lc3b_fetch_ctrl against a queue-based behavioural model.
module tb_lc3b_fetch_ctrl;
    localparam logic [15:0] RST_PC = 16'hFFFE;
    localparam int NCYC = 4000;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    lc3b_fetch_ctrl_if bus();

    lc3b_fetch_ctrl #(.RESET_PC(RST_PC), .PC_INC(16'd2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model state: instruction address to fetch next, words held back from decode,
    // and a redirect waiting for the in-flight fetch to finish.
    logic [15:0] m_pc;
    logic [15:0] held[$];
    bit          m_pend;
    logic [15:0] m_tgt;
    logic [15:0] m_cnt;

    logic        e_read, e_load;
    logic [15:0] e_addr, e_word, e_irpc;

    initial begin
        rst_n           = 1'b0;
        bus.imem_rdata  = 16'h0000;
        bus.imem_resp   = 1'b0;
        bus.id_stall    = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 16'h0000;
        m_pc = 16'h0; m_pend = 0; m_tgt = 16'h0; m_cnt = 16'h0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            rst_n           = (cyc < 2) ? 1'b0 : ($urandom_range(0, 199) != 0);
            bus.imem_resp   = ($urandom_range(0, 1) == 1);
            bus.imem_rdata  = 16'($urandom);
            bus.id_stall    = ($urandom_range(0, 9) < 4);
            bus.redirect    = ($urandom_range(0, 9) < 2);
            case ($urandom_range(0, 3))
                0:       bus.redirect_pc = 16'hFFFC;
                1:       bus.redirect_pc = 16'h3000;
                default: bus.redirect_pc = 16'($urandom);
            endcase
            #1;

            e_read = 0; e_addr = 0; e_load = 0; e_word = 0; e_irpc = 0;
            if (!rst_n) begin
                check_val("fetch_count", bus.fetch_count, 16'h0000);
                m_pc = RST_PC; held.delete(); m_pend = 0; m_tgt = 16'h0; m_cnt = 16'h0;
            end else begin
                check_val("fetch_count", bus.fetch_count, m_cnt);
                if (held.size() == 0) begin
                    e_read = 1; e_addr = m_pc;
                    if (bus.imem_resp) begin
                        if (bus.redirect)      begin m_pc = bus.redirect_pc; m_pend = 0; end
                        else if (m_pend)       begin m_pc = m_tgt; m_pend = 0; end
                        else if (bus.id_stall) held.push_back(bus.imem_rdata);
                        else begin
                            e_load = 1; e_word = bus.imem_rdata; e_irpc = m_pc + 16'd2;
                            m_pc = m_pc + 16'd2; m_cnt = m_cnt + 16'd1;
                        end
                    end else if (bus.redirect) begin
                        m_pend = 1; m_tgt = bus.redirect_pc;
                    end
                end else begin
                    if (bus.redirect) begin
                        held.delete(); m_pc = bus.redirect_pc;
                    end else if (!bus.id_stall) begin
                        e_load = 1; e_word = held.pop_front(); e_irpc = m_pc + 16'd2;
                        m_pc = m_pc + 16'd2; m_cnt = m_cnt + 16'd1;
                    end
                end
            end
            check_val("imem_read", {15'h0, bus.imem_read}, {15'h0, e_read});
            check_val("imem_address", bus.imem_address, e_addr);
            check_val("ir_load", {15'h0, bus.ir_load}, {15'h0, e_load});
            check_val("ir_word", bus.ir_word, e_word);
            check_val("ir_pc", bus.ir_pc, e_irpc);
            if (e_load)
                $display("cyc %0d deliver word=%h ir_pc=%h count=%h", cyc, e_word, e_irpc, m_cnt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lc3b_fetch_ctrl.md
Name: lc3b_fetch_ctrl

Overview:
Instruction-fetch sequencer for the LC-3b core. It owns the fetch PC, drives the instruction-memory read handshake, and generates the load strobe and data for the instruction register. It absorbs downstream stalls with a one-word hold buffer and handles control-flow redirects, including redirects that arrive while a memory request is in flight. It sits between instruction memory and the IR/decode stage.

Parameters:
RESET_PC, 16'h0000, fetch address after reset
PC_INC, 16'd2, byte increment per fetched instruction word

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
imem_read  out  1  instruction memory read request
imem_address  out  16  instruction fetch address
imem_rdata  in  16  instruction word returned by memory
imem_resp  in  1  memory response; imem_rdata is valid this cycle
id_stall  in  1  decode cannot accept an instruction this cycle
redirect  in  1  branch/JSR/TRAP redirect strobe
redirect_pc  in  16  redirect target, valid with redirect
ir_load  out  1  IR load strobe
ir_word  out  16  instruction word to IR
ir_pc  out  16  PC of the instruction plus PC_INC (LC-3b incremented PC)
fetch_count  out  16  count of instructions delivered

Behaviour:
- Reset: one clk with rst_n=0 gives the following state.
  - State S_REQ; pc=RESET_PC; hold buffer cleared; redir_pend=0; redir_tgt=0; fetch_count=0.
  - All outputs are low or zero during any cycle in which rst_n=0.
  - Reset mid-request abandons the request. A response arriving in the reset cycle is ignored.
- States: S_REQ (request outstanding) and S_HOLD (word buffered, no request).
- S_REQ outputs:
  - imem_read=1, imem_address=pc.
  - The request stays asserted with a stable address until imem_resp.
  - A redirect never changes imem_address mid-request.
- S_REQ, redirect=1 without imem_resp: latch redir_pend=1 and redir_tgt=redirect_pc. If pending is already set, the latest redirect overwrites the target.
- S_REQ, imem_resp=1, evaluated in priority order:
  1. redirect=1: discard rdata; pc<=redirect_pc; clear pending; stay S_REQ.
  2. redir_pend=1: discard rdata; pc<=redir_tgt; clear pending; stay S_REQ.
  3. id_stall=1: buffer imem_rdata; go S_HOLD; pc unchanged.
  4. Otherwise: ir_load=1 this cycle (combinational), ir_word=imem_rdata, ir_pc=pc+PC_INC; pc<=pc+PC_INC; fetch_count++; stay S_REQ. The next request issues the following cycle with no bubble beyond memory latency.
- S_HOLD outputs: imem_read=0.
- S_HOLD transitions:
  - redirect=1: drop the buffer; pc<=redirect_pc; go S_REQ. Redirect wins over id_stall.
  - Else id_stall=0: ir_load=1, ir_word=buffer, ir_pc=pc+PC_INC; pc<=pc+PC_INC; fetch_count++; go S_REQ.
  - Else: stay S_HOLD; the buffer is held unchanged.
- ir_load is never asserted in the same cycle as redirect.
- ir_word and ir_pc are 0 whenever ir_load=0.
- Arithmetic:
  - pc+PC_INC is 16-bit and wraps 16'hFFFE→16'h0000.
  - fetch_count wraps 16'hFFFF→16'h0000.
  - redirect_pc is used as given; bit 0 is not masked.
- imem_resp is ignored in S_HOLD.

Test Plan:
- Sequential fetch: reset, memory resp 1 cycle after each read, words 16'h1234, 16'h5678 → imem_address 0x0000 then 0x0002; ir_load pulses with ir_word 1234/ir_pc 0x0002, then 5678/0x0004; fetch_count=2.
- Stall: id_stall=1 when resp returns 16'hABCD → no ir_load, imem_read=0 for 3 stall cycles; ir_load with ABCD the cycle id_stall drops; next request at pc+2.
- Redirect in flight: redirect to 0x3000 two cycles before resp of a 0x0004 fetch → address stays 0x0004 until resp; rdata discarded; next imem_address=0x3000; fetch_count unchanged.
- Redirect coincident with resp and stall: resp, redirect to 0x4000, and id_stall all asserted in the same cycle → no ir_load, no buffering; next request to 0x4000.
- Redirect in S_HOLD: buffered word, then redirect to 0x0100 with id_stall=1 → buffer dropped, S_REQ at 0x0100; the buffered word is never delivered.
- Wrap and reset: RESET_PC=16'hFFFE, one fetch → ir_pc=0x0000 and next address 0x0000; then rst_n=0 mid-request → outputs zero; address back to 0xFFFE after release.
